digit_accumulator: RTL and testbench

- Parametrised successor to the 3-digit keypad operand converter.
- Buffers up to MAX_DIGITS decimal digits from the keyboard decoder, with backspace and clear.
- On commit, converts the buffer to binary serially, one digit per clock, using multiply-by-10-and-add.
- Feeds the ALU operand registers; reports saturation and rejected digits.

---
 rtl/digit_accumulator.sv | 145 ++++++++++++++
 tb/tb_digit_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_accumulator.sv
// Keypad digit entry buffer with backspace/clear, followed by a serial
// decimal-to-binary conversion (one digit per clock) with saturation.
module digit_accumulator #(
   parameter int MAX_DIGITS = 3,
   parameter int WIDTH      = 16,
   parameter int ASCII_IN   = 0
) (
   input  logic                             FPGAClk,
   input  logic                             rst_n,
   input  logic                             digit_valid,
   input  logic [7:0]                       digit_in,
   output logic                             digit_ready,
   input  logic                             backspace,
   input  logic                             clear,
   input  logic                             commit,
   output logic                             busy,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
   output logic [WIDTH-1:0]                 value,
   output logic                             value_valid,
   output logic                             overflow,
   output logic                             bad_digit
);

   localparam int CW = $clog2(MAX_DIGITS+1);

   typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;

   state_t                       state, state_d;
   logic [CW-1:0]                cnt, cnt_d, idx, idx_d;
   logic [MAX_DIGITS-1:0][3:0]   dbuf;
   logic [WIDTH-1:0]             acc, acc_d, value_d;
   logic                         ovf, ovf_d, overflow_d, vv_d, bad_d, wr_en;
   logic [7:0]                   code;
   logic                         code_ok;
   logic [3:0]                   dig, cur;
   logic [WIDTH+3:0]             acc_x, acc_nx;

   // ASCII codes below '0' wrap to large values and fail the range check
   always_comb begin
      code = (ASCII_IN != 0) ? (digit_in - 8'h30) : digit_in;
      code_ok = (code <= 8'd9);
      dig = code[3:0];
   end

   always_comb begin
      cur = '0;
      for (int i = 0; i < MAX_DIGITS; i++)
         if (idx == CW'(i)) cur = dbuf[i];
   end

   // acc*10 as shift-and-add; WIDTH+4 bits cannot overflow for acc <= 2^WIDTH-1
   always_comb begin
      acc_x  = {4'b0000, acc};
      acc_nx = (acc_x << 3) + (acc_x << 1) + {{WIDTH{1'b0}}, cur};
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      idx_d      = idx;
      acc_d      = acc;
      ovf_d      = ovf;
      value_d    = value;
      overflow_d = overflow;
      vv_d       = 1'b0;
      bad_d      = 1'b0;
      wr_en      = 1'b0;
      case (state)
         ENTRY: begin
            if (clear) begin
               cnt_d = '0;
            end else if (commit) begin
               idx_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = (cnt == '0) ? DONE : CONVERT;
            end else if (backspace) begin
               if (cnt != '0) cnt_d = cnt - CW'(1);
            end else if (digit_valid) begin
               if (code_ok && (cnt < CW'(MAX_DIGITS))) begin
                  wr_en = 1'b1;
                  cnt_d = cnt + CW'(1);
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         CONVERT: begin
            if (clear) begin
               state_d = ENTRY;
               cnt_d   = '0;
            end else begin
               if (acc_nx[WIDTH+3:WIDTH] != 4'b0000) begin
                  acc_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = acc_nx[WIDTH-1:0];
               end
               idx_d = idx + CW'(1);
               if (idx == cnt - CW'(1)) state_d = DONE;
            end
         end
         DONE: begin
            value_d    = acc;
            overflow_d = ovf;
            vv_d       = 1'b1;
            cnt_d      = '0;
            state_d    = ENTRY;
         end
         default: state_d = ENTRY;
      endcase
   end

   always_ff @(posedge FPGAClk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ENTRY;
         cnt         <= '0;
         idx         <= '0;
         acc         <= '0;
         ovf         <= 1'b0;
         dbuf        <= '0;
         value       <= '0;
         overflow    <= 1'b0;
         value_valid <= 1'b0;
         bad_digit   <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         acc         <= acc_d;
         ovf         <= ovf_d;
         value       <= value_d;
         overflow    <= overflow_d;
         value_valid <= vv_d;
         bad_digit   <= bad_d;
         for (int i = 0; i < MAX_DIGITS; i++)
            if (wr_en && (cnt == CW'(i))) dbuf[i] <= dig;
      end
   end

   assign digit_ready = (state == ENTRY);
   assign busy        = (state != ENTRY);
   assign digit_count = cnt;

endmodule

// File: tb/tb_digit_accumulator.sv
// Drives three digit_accumulator variants (16-bit raw, 8-bit raw, 16-bit ASCII)
// with one shared key stream; results are checked against an integer model.
module tb_digit_accumulator;

   logic FPGAClk = 1'b0;
   logic rst_n = 1'b0;
   logic digit_valid = 1'b0, backspace = 1'b0, clear = 1'b0, commit = 1'b0;
   logic [7:0] din = '0, din_c = '0;

   logic        ready_a, busy_a, vv_a, ov_a, bad_a;
   logic        ready_b, busy_b, vv_b, ov_b, bad_b;
   logic        ready_c, busy_c, vv_c, ov_c, bad_c;
   logic [1:0]  cnt_a, cnt_b, cnt_c;
   logic [15:0] val_a, val_c;
   logic [7:0]  val_b;

   always #5 FPGAClk = ~FPGAClk;

   digit_accumulator #(.MAX_DIGITS(3), .WIDTH(16), .ASCII_IN(0)) ua (
      .FPGAClk(FPGAClk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(din),
      .digit_ready(ready_a), .backspace(backspace), .clear(clear), .commit(commit),
      .busy(busy_a), .digit_count(cnt_a), .value(val_a), .value_valid(vv_a),
      .overflow(ov_a), .bad_digit(bad_a));

   digit_accumulator #(.MAX_DIGITS(3), .WIDTH(8), .ASCII_IN(0)) ub (
      .FPGAClk(FPGAClk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(din),
      .digit_ready(ready_b), .backspace(backspace), .clear(clear), .commit(commit),
      .busy(busy_b), .digit_count(cnt_b), .value(val_b), .value_valid(vv_b),
      .overflow(ov_b), .bad_digit(bad_b));

   digit_accumulator #(.MAX_DIGITS(3), .WIDTH(16), .ASCII_IN(1)) uc (
      .FPGAClk(FPGAClk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(din_c),
      .digit_ready(ready_c), .backspace(backspace), .clear(clear), .commit(commit),
      .busy(busy_c), .digit_count(cnt_c), .value(val_c), .value_valid(vv_c),
      .overflow(ov_c), .bad_digit(bad_c));

   typedef enum {KEY, BKSP, CLR, CMT} op_t;
   typedef struct {
      op_t        op;
      logic [7:0] raw;
      logic [7:0] asc;
      int         cnt;
      bit         bad;
   } vec_t;
   typedef struct {
      longint v16;
      bit     o16;
      longint v8;
      bit     o8;
   } sb_t;

   vec_t   tbl[$];
   sb_t    sb_q[$];
   int     mdl[$];
   int     ntests = 0, nfail = 0;
   longint last16 = 0, last8 = 0;
   bit     lasto16 = 0, lasto8 = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge FPGAClk);
      #1;
   endtask

   function automatic void add(op_t op, logic [7:0] r, logic [7:0] a, int c, bit b);
      vec_t v;
      v = '{op, r, a, c, b};
      tbl.push_back(v);
   endfunction

   function automatic void k(logic [7:0] r, int c, bit b);
      add(KEY, r, r + 8'h30, c, b);
   endfunction

   function automatic void calc(input longint lim, output longint v, output bit o);
      v = 0;
      o = 0;
      foreach (mdl[i]) begin
         v = v * 10 + mdl[i];
         if (v > lim) begin
            v = lim;
            o = 1;
         end
      end
   endfunction

   function automatic sb_t expect_now();
      sb_t e;
      calc(65535, e.v16, e.o16);
      calc(255, e.v8, e.o8);
      return e;
   endfunction

   task automatic key(input logic [7:0] r, input logic [7:0] a);
      digit_valid = 1'b1;
      din = r;
      din_c = a;
      tick();
      digit_valid = 1'b0;
      if (r <= 8'd9 && mdl.size() < 3) mdl.push_back(int'(r));
   endtask

   task automatic do_commit();
      sb_t e;
      int n;
      e = expect_now();
      sb_q.push_back(e);
      last16 = e.v16; lasto16 = e.o16; last8 = e.v8; lasto8 = e.o8;
      n = mdl.size();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk("convert busy/vv/ready", {busy_a, vv_a, ready_a}, 3'b100);
         tick();
      end
      chk("done busy/vv/ready", {busy_a, vv_a, ready_a}, 3'b100);
      tick();
      chk("latency vv/busy/ready", {vv_a, busy_a, ready_a}, 3'b101);
      mdl.delete();
   endtask

   // Every value_valid pulse must match the oldest outstanding expectation
   always @(negedge FPGAClk) begin
      if (rst_n && (vv_a || vv_b || vv_c)) begin
         chk("vv agreement", {vv_a, vv_b, vv_c}, 3'b111);
         if (sb_q.size() == 0) begin
            chk("unexpected value_valid", 1, 0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("value w16", val_a, e.v16);
            chk("overflow w16", ov_a, e.o16);
            chk("value w8", val_b, e.v8);
            chk("overflow w8", ov_b, e.o8);
            chk("value ascii", val_c, e.v16);
            chk("overflow ascii", ov_c, e.o16);
         end
      end
   end

   initial begin
      k(1, 1, 0); k(2, 2, 0); k(3, 3, 0); add(CMT, 0, 0, 0, 0);
      k(4, 1, 0); k(5, 2, 0); add(BKSP, 0, 0, 1, 0); k(7, 2, 0); add(CMT, 0, 0, 0, 0);
      add(BKSP, 0, 0, 0, 0);
      add(KEY, 8'd10, 8'h2F, 0, 1);
      k(9, 1, 0); k(9, 2, 0); k(9, 3, 0); k(9, 3, 1);
      add(KEY, 8'd12, 8'h41, 3, 1); add(CMT, 0, 0, 0, 0);
      k(3, 1, 0); k(0, 2, 0); k(0, 3, 0); add(CMT, 0, 0, 0, 0);
      k(2, 1, 0); k(5, 2, 0); k(5, 3, 0); add(CMT, 0, 0, 0, 0);
      k(4, 1, 0); k(2, 2, 0); add(CMT, 0, 0, 0, 0);
      add(CMT, 0, 0, 0, 0);
      k(8, 1, 0); add(CLR, 0, 0, 0, 0); add(CMT, 0, 0, 0, 0);
      k(0, 1, 0); k(0, 2, 0); k(7, 3, 0); add(CMT, 0, 0, 0, 0);

      repeat (2) @(posedge FPGAClk);
      #1;
      chk("reset cnt", cnt_a, 0);
      chk("reset value", val_a, 0);
      chk("reset flags vv/ov/bad/busy", {vv_a, ov_a, bad_a, busy_a}, 4'b0000);
      chk("reset ready", ready_a, 1);
      @(negedge FPGAClk);
      rst_n = 1'b1;
      tick();

      foreach (tbl[i]) begin
         case (tbl[i].op)
            KEY:  key(tbl[i].raw, tbl[i].asc);
            BKSP: begin
               backspace = 1'b1; tick(); backspace = 1'b0;
               if (mdl.size() > 0) void'(mdl.pop_back());
            end
            CLR: begin
               clear = 1'b1; tick(); clear = 1'b0;
               mdl.delete();
            end
            CMT:  do_commit();
            default: ;
         endcase
         chk($sformatf("step %0d count", i), cnt_a, tbl[i].cnt);
         chk($sformatf("step %0d count w8/ascii", i), {cnt_b, cnt_c}, {2'(tbl[i].cnt), 2'(tbl[i].cnt)});
         chk($sformatf("step %0d bad_digit", i), {bad_a, bad_b, bad_c}, {3{tbl[i].bad}});
      end

      // clear on the second CONVERT cycle of "567" aborts without publishing
      key(5, 8'h35); key(6, 8'h36); key(7, 8'h37);
      commit = 1'b1; tick(); commit = 1'b0;
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      mdl.delete();
      chk("abort busy", busy_a, 0);
      chk("abort count", cnt_a, 0);
      repeat (4) tick();
      chk("abort value kept", val_a, last16);
      chk("abort overflow kept", ov_a, lasto16);
      chk("abort value w8 kept", val_b, last8);

      // clear during DONE is ignored
      key(8, 8'h38);
      sb_q.push_back(expect_now());
      commit = 1'b1; tick(); commit = 1'b0;
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      mdl.delete();
      chk("done-clear vv", vv_a, 1);
      chk("done-clear value", val_a, 8);
      chk("done-clear count", cnt_a, 0);

      // asynchronous reset mid-entry
      tick();
      key(1, 8'h31); key(2, 8'h32);
      chk("pre-reset count", cnt_a, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset count", {cnt_a, cnt_b, cnt_c}, 6'd0);
      chk("async reset value", val_a, 0);
      chk("async reset value w8/ascii", {val_b, val_c}, 24'd0);
      chk("async reset flags", {vv_a, ov_a, bad_a, busy_a, ov_b, ov_c}, 6'd0);
      mdl.delete();
      @(negedge FPGAClk);
      rst_n = 1'b1;
      tick();
      key(6, 8'h36);
      do_commit();
      tick();

      chk("scoreboard drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
